// File: rtl/uart_tx_arbiter_if.sv
// UART TX arbiter bus: two byte requesters in, one transmitter out.
// slave = the arbiter, master = whatever drives the requesters/UART.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [1:0] grant;
  logic       overrun;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  tx_ready,
    output req0_ready, req1_ready,
    output tx_valid, tx_data,
    output grant, overrun
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output tx_ready,
    input  req0_ready, req1_ready,
    input  tx_valid, tx_data,
    input  grant, overrun
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART transmitter.
// A grant holds until the packet's last byte or MAX_PKT bytes.
module uart_tx_arbiter #(
  parameter int MAX_PKT = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam logic [7:0] CNT_LIM = 8'(MAX_PKT - 1);

  logic [0:0] state;
  logic       owner;
  logic       ptr;
  logic [7:0] cnt;
  logic       ovf;

  logic       locked;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       xfer;
  logic       pick;

  assign locked = (state == LOCK);

  // mux the granted requester onto the transmitter side
  always_comb begin
    sel_valid = bus.req0_valid;
    sel_last  = bus.req0_last;
    sel_data  = bus.req0_data;
    if (owner) begin
      sel_valid = bus.req1_valid;
      sel_last  = bus.req1_last;
      sel_data  = bus.req1_data;
    end
  end

  assign bus.tx_valid   = locked & sel_valid;
  assign bus.tx_data    = locked ? sel_data : 8'h00;
  assign bus.req0_ready = locked & ~owner & bus.tx_ready;
  assign bus.req1_ready = locked & owner & bus.tx_ready;
  assign bus.grant      = locked ? {owner, ~owner} : 2'b00;
  assign bus.overrun    = ovf;

  assign xfer = bus.tx_valid & bus.tx_ready;

  // ptr holds the last served id; on a tie the other one wins
  assign pick = (bus.req0_valid & bus.req1_valid) ? ~ptr
              : bus.req1_valid;

  // grant/release state machine with byte counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr   <= 1'b1;
      cnt   <= 8'd0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.req0_valid | bus.req1_valid) begin
            state <= LOCK;
            owner <= pick;
            cnt   <= 8'd0;
          end
        end
        (state == LOCK): begin
          if (xfer) begin
            if (sel_last) begin
              state <= IDLE;
              ptr   <= owner;
              cnt   <= 8'd0;
            end else if (cnt == CNT_LIM) begin
              state <= IDLE;
              ptr   <= owner;
              cnt   <= 8'd0;
              ovf   <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, corner sequences,
// then random traffic against a packet-level reference model.
module tb_uart_tx_arbiter;

  localparam int MAX_PKT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.MAX_PKT(MAX_PKT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       txr;
    logic       chk;
    logic [1:0] g;
    logic       txv;
    logic [7:0] txd;
    logic       r0;
    logic       r1;
    logic       ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic v0, input logic [7:0] d0,
    input logic l0, input logic v1, input logic [7:0] d1,
    input logic l1, input logic txr, input logic chk,
    input logic [1:0] g, input logic txv,
    input logic [7:0] txd, input logic r0,
    input logic r1, input logic ov);
    vec_t v;
    v.r = r; v.v0 = v0; v.d0 = d0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.l1 = l1; v.txr = txr;
    v.chk = chk; v.g = g; v.txv = txv; v.txd = txd;
    v.r0 = r0; v.r1 = r1; v.ov = ov;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag,
    input logic [1:0] g, input logic txv,
    input logic [7:0] txd, input logic r0,
    input logic r1, input logic ov);
    check({tag, "_grant"}, 32'(bus.grant), 32'(g));
    check({tag, "_txv"}, 32'(bus.tx_valid), 32'(txv));
    if (txv)
      check({tag, "_txd"}, 32'(bus.tx_data), 32'(txd));
    check({tag, "_rdy0"}, 32'(bus.req0_ready), 32'(r0));
    check({tag, "_rdy1"}, 32'(bus.req1_ready), 32'(r1));
    check({tag, "_ovr"}, 32'(bus.overrun), 32'(ov));
  endtask

  // inputs change 1 after the edge; outputs sampled at negedge
  task automatic cyc(
    input logic r, input logic v0, input logic [7:0] d0,
    input logic l0, input logic v1, input logic [7:0] d1,
    input logic l1, input logic txr);
    @(posedge clk);
    #1;
    rst            = r;
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req0_last  = l0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.req1_last  = l1;
    bus.tx_ready   = txr;
    #4;
  endtask

  // reference model: who owns the UART, how many bytes sent,
  // who is next in line on a tie
  int m_owner;
  int m_pref;
  int m_sent;
  bit m_ov;

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req0_last  = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.req1_last  = 1'b0;
    bus.tx_ready   = 1'b0;

    // single packet, backpressured packet, lock holding
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,8'hA5,0,0,0,0,1, 1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,8'hA5,0,0,0,0,1, 1, 1,1,8'hA5,1,0,0));
    tbl.push_back(mk(0,1,8'h5A,1,0,0,0,1, 1, 1,1,8'h5A,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,8'h10,0,1, 1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,8'h10,0,0, 1, 2,1,8'h10,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,8'h10,0,1, 1, 2,1,8'h10,0,1,0));
    tbl.push_back(mk(0,1,8'hEE,1,1,8'h11,0,0, 1, 2,1,8'h11,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,8'h11,0,1, 1, 2,1,8'h11,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,8'h12,0,1, 1, 2,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h12,0,0, 1, 2,1,8'h12,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,8'h12,0,1, 1, 2,1,8'h12,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h13,1,0, 1, 2,1,8'h13,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,8'h13,1,1, 1, 2,1,8'h13,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1, 0,0,0,0,0,0));

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].v0, tbl[i].d0, tbl[i].l0,
          tbl[i].v1, tbl[i].d1, tbl[i].l1, tbl[i].txr);
      if (tbl[i].chk)
        check_outs($sformatf("tbl%0d", i), tbl[i].g,
                   tbl[i].txv, tbl[i].txd, tbl[i].r0,
                   tbl[i].r1, tbl[i].ov);
    end

    // contention after reset: req0 first, then alternation
    cyc(1,0,0,0,0,0,0,1);
    cyc(0,1,8'h01,0,1,8'h81,0,1);
    check_outs("arb_idle", 0,0,0,0,0,0);
    cyc(0,1,8'h01,0,1,8'h81,0,1);
    check_outs("arb_g0a", 1,1,8'h01,1,0,0);
    cyc(0,1,8'h02,1,1,8'h81,0,1);
    check_outs("arb_g0b", 1,1,8'h02,1,0,0);
    cyc(0,0,0,0,1,8'h81,0,1);
    check_outs("arb_dead", 0,0,0,0,0,0);
    cyc(0,0,0,0,1,8'h81,0,1);
    check_outs("arb_g1a", 2,1,8'h81,0,1,0);
    cyc(0,1,8'h03,1,1,8'h82,1,1);
    check_outs("arb_g1b", 2,1,8'h82,0,1,0);
    cyc(0,1,8'h03,1,1,8'h83,0,1);
    check_outs("arb_dead2", 0,0,0,0,0,0);
    cyc(0,1,8'h03,1,1,8'h83,0,1);
    check_outs("arb_alt", 1,1,8'h03,1,0,0);

    // forced release after MAX_PKT bytes without last
    cyc(1,0,0,0,0,0,0,1);
    cyc(0,0,0,0,1,8'h00,0,1);
    check_outs("ovr_idle", 0,0,0,0,0,0);
    for (int i = 0; i < MAX_PKT; i++) begin
      cyc(0,1,8'hC0,1,1,8'(i),0,1);
      check_outs($sformatf("ovr_b%0d", i),
                 2,1,8'(i),0,1,0);
    end
    cyc(0,1,8'hC0,1,1,8'(MAX_PKT),0,1);
    check_outs("ovr_pulse", 0,0,0,0,0,1);
    cyc(0,1,8'hC0,1,1,8'(MAX_PKT),0,1);
    check_outs("ovr_next", 1,1,8'hC0,1,0,0);
    cyc(0,0,0,0,0,0,0,1);
    check_outs("ovr_end", 0,0,0,0,0,0);

    // reset in the middle of a 5-byte packet
    cyc(1,0,0,0,0,0,0,1);
    cyc(0,0,0,0,1,8'h50,0,1);
    check_outs("rmp_idle", 0,0,0,0,0,0);
    cyc(0,0,0,0,1,8'h50,0,1);
    check_outs("rmp_b0", 2,1,8'h50,0,1,0);
    cyc(0,0,0,0,1,8'h51,0,1);
    check_outs("rmp_b1", 2,1,8'h51,0,1,0);
    cyc(1,0,0,0,1,8'h52,0,1);
    check_outs("rmp_rst", 2,1,8'h52,0,1,0);
    cyc(0,1,8'h60,1,1,8'h52,0,1);
    check_outs("rmp_after", 0,0,0,0,0,0);
    cyc(0,1,8'h60,1,1,8'h52,0,1);
    check_outs("rmp_req0", 1,1,8'h60,1,0,0);

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic       r, v0, l0, v1, l1, txr;
      logic [7:0] d0, d1;
      logic [1:0] eg;
      logic       etv, er0, er1, elast;
      logic [7:0] etd;
      int         lm;
      lm  = (n < 1500) ? 6 : 30;
      r   = (n == 0) || ($urandom_range(0, 299) == 0);
      v0  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      d0  = 8'($urandom);
      d1  = 8'($urandom);
      l0  = ($urandom_range(0, lm) == 0);
      l1  = ($urandom_range(0, lm) == 0);
      txr = ($urandom_range(0, 3) != 0);
      cyc(r, v0, d0, l0, v1, d1, l1, txr);

      eg    = (m_owner < 0) ? 2'b00
            : (m_owner == 0) ? 2'b01 : 2'b10;
      etv   = (m_owner == 0 && v0) || (m_owner == 1 && v1);
      etd   = (m_owner == 1) ? d1 : d0;
      elast = (m_owner == 1) ? l1 : l0;
      er0   = (m_owner == 0) && txr;
      er1   = (m_owner == 1) && txr;
      if (n != 0)
        check_outs("rnd", eg, etv, etd, er0, er1, m_ov);

      if (r) begin
        m_owner = -1;
        m_pref  = 0;
        m_sent  = 0;
        m_ov    = 0;
      end else begin
        m_ov = 0;
        if (m_owner < 0) begin
          if (v0 && v1) m_owner = m_pref;
          else if (v0) m_owner = 0;
          else if (v1) m_owner = 1;
          m_sent = 0;
        end else if (etv && txr) begin
          m_sent++;
          if (elast || m_sent == MAX_PKT) begin
            m_ov    = !elast;
            m_pref  = 1 - m_owner;
            m_owner = -1;
            m_sent  = 0;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_PKT, default 16: max bytes one requester may send per grant before forced release (legal range 2..255).
REQ-002 The module SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port req0_valid, input, 1, requester 0 (command response) has a byte.
REQ-005 The module SHALL have port req0_data, input, 8, requester 0 byte.
REQ-006 The module SHALL have port req0_last, input, 1, requester 0 byte is final of packet.
REQ-007 The module SHALL have port req0_ready, output, 1, requester 0 byte accepted this cycle.
REQ-008 The module SHALL have ports req1_valid, req1_data, req1_last, req1_ready, identical to REQ-004..007 for requester 1 (sample stream).
REQ-009 The module SHALL have port tx_valid, output, 1, byte offered to UART transmitter.
REQ-010 The module SHALL have port tx_data, output, 8, byte to UART transmitter.
REQ-011 The module SHALL have port tx_ready, input, 1, UART transmitter idle and accepting.
REQ-012 The module SHALL have port grant, output, 2, one-hot current owner (bit0 = req0, bit1 = req1), 2'b00 when idle.
REQ-013 The module SHALL have port overrun, output, 1, one-cycle pulse on forced release.

Function
REQ-014 A byte transfer SHALL occur only in a cycle where tx_valid and tx_ready are both 1.
REQ-015 FSM SHALL have two states: IDLE and LOCK.
REQ-016 In IDLE: grant = 00, tx_valid = 0, req0_ready = req1_ready = 0; no byte consumed.
REQ-017 In IDLE, when exactly one reqN_valid = 1: next cycle LOCK with grant to N (1-cycle grant latency).
REQ-018 In IDLE, both valid: grant to the requester NOT served last (round-robin pointer); after reset pointer favours req0.
REQ-019 In LOCK: tx_valid = granted reqN_valid, tx_data = granted reqN_data, granted reqN_ready = tx_ready (combinational pass-through); non-granted ready = 0.
REQ-020 Byte counter (8 bit) SHALL clear on entry to LOCK and increment on each transfer.
REQ-021 Transfer with granted last = 1: next state IDLE, pointer records served requester, counter cleared.
REQ-022 Transfer with last = 0 and counter = MAX_PKT-1 (MAX_PKT-th byte): next state IDLE, overrun = 1 for exactly that next cycle, pointer updated as REQ-021.
REQ-023 Granted requester deasserting valid mid-packet SHALL NOT release grant; LOCK held indefinitely until last or MAX_PKT.
REQ-024 Non-granted requester's valid/data SHALL have no effect while LOCK; it waits, its bytes never interleave.
REQ-025 tx_ready low SHALL stall without dropping or duplicating bytes; counter increments only on transfer.
REQ-026 Return to IDLE SHALL cost one dead cycle between packets (no back-to-back re-grant in same cycle).

Reset
REQ-027 With rst = 1 at a clock edge: state IDLE, grant = 00, overrun = 0, counter = 0, pointer favours req0; tx_valid and both readys = 0 the following cycle.
REQ-028 Reset mid-packet SHALL abort the packet; no further bytes of it forwarded unless re-requested after reset.

Verification
REQ-029 Single packet: req0 sends 0xA5,0x5A(last), tx_ready = 1 -> grant = 01 one cycle after valid, tx_data 0xA5 then 0x5A, grant = 00 next cycle.
REQ-030 Contention: req0 and req1 valid same cycle after reset -> req0 packet completes, one idle cycle, then grant = 10; repeat -> req0 served again only after req1 (alternation).
REQ-031 Overrun: MAX_PKT = 16, req1 streams 20 bytes with last = 0 -> 16 transfers, overrun pulse 1 cycle, grant 00; req0 pending then granted.
REQ-032 Backpressure: tx_ready toggled 1/0 every cycle during 4-byte packet -> exactly 4 transfers, order preserved, req ready mirrors tx_ready.
REQ-033 Reset mid-packet: rst after 2nd of 5 bytes -> grant = 00, tx_valid = 0 next cycle, counter 0, next request granted req0-first.
